// File: rtl/head_table_lookup.sv
// head_table_lookup
// Bucket head-pointer table. Each command is accepted into a shadow pipeline that
// runs alongside the RAM read. The pointer read from the RAM (or a newer value
// written while the command was in flight) is merged with the command and
// pushed into a show-ahead output FIFO. A sequenced clear walks the table writing
// {0,0} to every entry.
module head_table_lookup #(
    parameter int BUCKET_WIDTH  = 10,
    parameter int PTR_WIDTH     = 8,
    parameter int PAYLOAD_WIDTH = 64,
    parameter int RAM_LATENCY   = 2,
    parameter int OUT_DEPTH     = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [BUCKET_WIDTH-1:0]  bucket_i,
    input  logic [PAYLOAD_WIDTH-1:0] payload_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    output logic [BUCKET_WIDTH-1:0]  bucket_o,
    output logic [PAYLOAD_WIDTH-1:0] payload_o,
    output logic [PTR_WIDTH-1:0]     head_ptr_o,
    output logic                     head_ptr_val_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    input  logic [BUCKET_WIDTH-1:0]  wr_addr_i,
    input  logic [PTR_WIDTH-1:0]     wr_data_ptr_i,
    input  logic                     wr_data_ptr_val_i,
    input  logic                     wr_en_i,
    input  logic                     clear_run_i,
    output logic                     clear_done_o
);

    localparam int ENTRIES = 1 << BUCKET_WIDTH;
    localparam int ENTRY_W = PTR_WIDTH + 1;
    localparam int FIFO_AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W   = $clog2(OUT_DEPTH + 1) + 1;
    localparam int FIFO_W  = BUCKET_WIDTH + PAYLOAD_WIDTH + ENTRY_W;
    localparam int LAST    = RAM_LATENCY - 1;

    localparam logic [BUCKET_WIDTH-1:0] CLR_ZERO = {BUCKET_WIDTH{1'b0}};
    localparam logic [BUCKET_WIDTH-1:0] CLR_LAST = {BUCKET_WIDTH{1'b1}};
    localparam logic [BUCKET_WIDTH-1:0] CLR_STEP = BUCKET_WIDTH'(1'b1);
    localparam logic [FIFO_AW-1:0]      PTR_STEP = FIFO_AW'(1'b1);
    localparam logic [CNT_W-1:0]        CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]        CNT_STEP = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]        CNT_CAP  = CNT_W'(OUT_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic [BUCKET_WIDTH-1:0]   clr_cnt_r;
    logic [BUCKET_WIDTH-1:0]   clr_cnt_nxt_s;

    logic [ENTRY_W-1:0]        ram_r [ENTRIES];

    logic                      sh_valid_r   [RAM_LATENCY];
    logic [BUCKET_WIDTH-1:0]   sh_bucket_r  [RAM_LATENCY];
    logic [PAYLOAD_WIDTH-1:0]  sh_payload_r [RAM_LATENCY];
    logic                      ovr_set_r    [RAM_LATENCY];
    logic [ENTRY_W-1:0]        ovr_data_r   [RAM_LATENCY];
    logic [ENTRY_W-1:0]        rd_data_r    [RAM_LATENCY];
    logic [RAM_LATENCY-1:0]    hit_s;

    logic [FIFO_W-1:0]         fifo_mem_r [OUT_DEPTH];
    logic [FIFO_AW-1:0]        fifo_wr_ptr_r;
    logic [FIFO_AW-1:0]        fifo_rd_ptr_r;
    logic [CNT_W-1:0]          fifo_cnt_r;
    logic [CNT_W-1:0]          inflight_s;

    logic                      accept_s;
    logic                      ext_wr_s;
    logic                      clear_wr_s;
    logic                      acc_hit_s;
    logic [ENTRY_W-1:0]        wr_entry_s;
    logic [ENTRY_W-1:0]        merge_s;
    logic                      push_s;
    logic                      pop_s;
    logic [FIFO_W-1:0]         head_s;

    // External writes (and therefore bypass) are shut off while the clear walks the table.
    assign clear_wr_s = (state_r == CLEAR);
    assign ext_wr_s   = wr_en_i && (state_r != CLEAR);
    assign wr_entry_s = {wr_data_ptr_val_i, wr_data_ptr_i};
    assign accept_s   = valid_i && ready_o;
    assign acc_hit_s  = ext_wr_s && (bucket_i == wr_addr_i);

    assign valid_o  = (fifo_cnt_r != CNT_ZERO);
    assign push_s   = sh_valid_r[LAST];
    assign pop_s    = valid_o && ready_i;
    // Credit: everything in flight plus everything buffered must leave room for one more.
    assign ready_o  = (state_r == IDLE) && ((inflight_s + fifo_cnt_r) < CNT_CAP);
    assign clear_done_o = (state_r == DONE);

    // Clear FSM next state and counter sequencing.
    always_comb begin
        state_nxt_s   = state_r;
        clr_cnt_nxt_s = clr_cnt_r;
        case (state_r)
            IDLE: begin
                if (clear_run_i) begin
                    state_nxt_s   = CLEAR;
                    clr_cnt_nxt_s = CLR_ZERO;
                end else begin
                    state_nxt_s   = IDLE;
                end
            end
            CLEAR: begin
                if (clr_cnt_r == CLR_LAST) begin
                    state_nxt_s = DONE;
                end else begin
                    clr_cnt_nxt_s = clr_cnt_r + CLR_STEP;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s   = IDLE;
                clr_cnt_nxt_s = CLR_ZERO;
            end
        endcase
    end

    // Clear FSM state and counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            clr_cnt_r <= CLR_ZERO;
        end else begin
            state_r   <= state_nxt_s;
            clr_cnt_r <= clr_cnt_nxt_s;
        end
    end

    // Table storage: clear writes take priority, external writes otherwise.
    always_ff @(posedge clk_i) begin
        if (clear_wr_s) begin
            ram_r[clr_cnt_r] <= {ENTRY_W{1'b0}};
        end else if (ext_wr_s) begin
            ram_r[wr_addr_i] <= wr_entry_s;
        end
    end

    // Which in-flight stages hold the bucket being written this cycle.
    always_comb begin
        for (int k = 0; k < RAM_LATENCY; k++) begin
            hit_s[k] = ext_wr_s && sh_valid_r[k] && (sh_bucket_r[k] == wr_addr_i);
        end
    end

    // Number of commands currently in the shadow pipeline.
    always_comb begin
        inflight_s = CNT_ZERO;
        for (int k = 0; k < RAM_LATENCY; k++) begin
            inflight_s = inflight_s + CNT_W'(sh_valid_r[k]);
        end
    end

    // Shadow pipeline control and override tracking; a write landing on a stage replaces any older override.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < RAM_LATENCY; k++) begin
                sh_valid_r[k] <= 1'b0;
                ovr_set_r[k]  <= 1'b0;
                ovr_data_r[k] <= {ENTRY_W{1'b0}};
            end
        end else begin
            sh_valid_r[0] <= accept_s;
            ovr_set_r[0]  <= accept_s && acc_hit_s;
            ovr_data_r[0] <= wr_entry_s;
            for (int k = 1; k < RAM_LATENCY; k++) begin
                sh_valid_r[k] <= sh_valid_r[k-1];
                ovr_set_r[k]  <= sh_valid_r[k-1] && (ovr_set_r[k-1] || hit_s[k-1]);
                ovr_data_r[k] <= hit_s[k-1] ? wr_entry_s : ovr_data_r[k-1];
            end
        end
    end

    // Shadow pipeline data and the RAM read pipeline (registered-output RAM model).
    always_ff @(posedge clk_i) begin
        sh_bucket_r[0]  <= bucket_i;
        sh_payload_r[0] <= payload_i;
        rd_data_r[0]    <= ram_r[bucket_i];
        for (int k = 1; k < RAM_LATENCY; k++) begin
            sh_bucket_r[k]  <= sh_bucket_r[k-1];
            sh_payload_r[k] <= sh_payload_r[k-1];
            rd_data_r[k]    <= rd_data_r[k-1];
        end
    end

    // Merge: a write in the merge cycle is youngest, then the stage override, then the RAM data.
    always_comb begin
        if (hit_s[LAST]) begin
            merge_s = wr_entry_s;
        end else if (ovr_set_r[LAST]) begin
            merge_s = ovr_data_r[LAST];
        end else begin
            merge_s = rd_data_r[LAST];
        end
    end

    // Output FIFO pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fifo_wr_ptr_r <= {FIFO_AW{1'b0}};
            fifo_rd_ptr_r <= {FIFO_AW{1'b0}};
            fifo_cnt_r    <= CNT_ZERO;
        end else begin
            if (push_s) begin
                fifo_wr_ptr_r <= fifo_wr_ptr_r + PTR_STEP;
            end
            if (pop_s) begin
                fifo_rd_ptr_r <= fifo_rd_ptr_r + PTR_STEP;
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_STEP;
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_STEP;
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Output FIFO storage.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            fifo_mem_r[fifo_wr_ptr_r] <= {sh_bucket_r[LAST], sh_payload_r[LAST], merge_s};
        end
    end

    // FIFO head drives the outputs; an empty FIFO presents zeros.
    always_comb begin
        head_s = fifo_mem_r[fifo_rd_ptr_r];
        if (fifo_cnt_r != CNT_ZERO) begin
            {bucket_o, payload_o, head_ptr_val_o, head_ptr_o} = head_s;
        end else begin
            {bucket_o, payload_o, head_ptr_val_o, head_ptr_o} = {FIFO_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_head_table_lookup.sv
// Directed and random bench for head_table_lookup (BUCKET_WIDTH = 4).
// A negedge monitor keeps a table model; each accepted command's expected
// result is the table value as of its merge edge, which is what the bypass
// rules amount to.
module tb_head_table_lookup;

    localparam int BW = 4;
    localparam int PW = 8;
    localparam int DW = 16;
    localparam int L  = 2;
    localparam int OD = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [BW-1:0] bucket_i;
    logic [DW-1:0] payload_i;
    logic          valid_i;
    logic          ready_o;
    logic [BW-1:0] bucket_o;
    logic [DW-1:0] payload_o;
    logic [PW-1:0] head_ptr_o;
    logic          head_ptr_val_o;
    logic          valid_o;
    logic          ready_i;
    logic [BW-1:0] wr_addr_i;
    logic [PW-1:0] wr_data_ptr_i;
    logic          wr_data_ptr_val_i;
    logic          wr_en_i;
    logic          clear_run_i;
    logic          clear_done_o;

    always #5 clk_i = ~clk_i;

    head_table_lookup #(
        .BUCKET_WIDTH(BW), .PTR_WIDTH(PW), .PAYLOAD_WIDTH(DW),
        .RAM_LATENCY(L), .OUT_DEPTH(OD)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .bucket_i(bucket_i), .payload_i(payload_i), .valid_i(valid_i), .ready_o(ready_o),
        .bucket_o(bucket_o), .payload_o(payload_o), .head_ptr_o(head_ptr_o),
        .head_ptr_val_o(head_ptr_val_o), .valid_o(valid_o), .ready_i(ready_i),
        .wr_addr_i(wr_addr_i), .wr_data_ptr_i(wr_data_ptr_i),
        .wr_data_ptr_val_i(wr_data_ptr_val_i), .wr_en_i(wr_en_i),
        .clear_run_i(clear_run_i), .clear_done_o(clear_done_o)
    );

    typedef struct packed {
        logic [BW-1:0] b;
        logic [DW-1:0] p;
        logic          v;
        logic [PW-1:0] ptr;
    } exp_t;

    typedef struct {
        logic [BW-1:0] b;
        logic [DW-1:0] p;
        int            due;
    } pend_t;

    int            checks = 0;
    int            errors = 0;
    exp_t          exp_q [$];
    pend_t         pend_q [$];
    logic [PW:0]   tbl [1 << BW];
    bit            model_clearing = 1'b0;
    int            cyc = 0;
    int            pops = 0;
    logic [PW-1:0] last_ptr = 8'h00;
    logic          last_val = 1'b0;
    exp_t          mon_e;
    exp_t          mon_obs;
    pend_t         mon_p;

    // Monitor: sampled at negedge, these are exactly the values the next posedge will use.
    always @(negedge clk_i) begin
        if (rst_i) begin
            exp_q.delete();
            pend_q.delete();
        end else begin
            if (valid_o && ready_i) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_unexpected observed bucket=%0h payload=%0h expected no output", bucket_o, payload_o);
                end
                if (exp_q.size() != 0) begin
                    mon_e   = exp_q.pop_front();
                    mon_obs = {bucket_o, payload_o, head_ptr_val_o, head_ptr_o};
                    checks++;
                    assert (mon_obs === mon_e) else begin
                        errors++;
                        $error("FAIL sb_output observed=%h expected=%h", mon_obs, mon_e);
                    end
                end
                last_ptr = head_ptr_o;
                last_val = head_ptr_val_o;
                pops++;
            end
            if (wr_en_i && !model_clearing) begin
                tbl[wr_addr_i] = {wr_data_ptr_val_i, wr_data_ptr_i};
            end
            while (pend_q.size() != 0 && pend_q[0].due == cyc) begin
                mon_p     = pend_q.pop_front();
                mon_e.b   = mon_p.b;
                mon_e.p   = mon_p.p;
                mon_e.v   = tbl[mon_p.b][PW];
                mon_e.ptr = tbl[mon_p.b][PW-1:0];
                exp_q.push_back(mon_e);
            end
            if (valid_i && ready_o) begin
                mon_p.b   = bucket_i;
                mon_p.p   = payload_i;
                mon_p.due = cyc + L;
                pend_q.push_back(mon_p);
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [BW-1:0] b, input logic [DW-1:0] p);
        int  n;
        bit  took;
        n    = 0;
        took = 1'b0;
        bucket_i  = b;
        payload_i = p;
        valid_i   = 1'b1;
        while (!took && n < 100) begin
            took = ready_o;
            step();
            n++;
        end
        valid_i = 1'b0;
        check("send_timeout", took, 1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        valid_i = 1'b0;
        wr_en_i = 1'b0;
        ready_i = 1'b1;
        while ((exp_q.size() != 0 || pend_q.size() != 0 || valid_o) && n < 200) begin
            step();
            n++;
        end
        check("drain_timeout", (n < 200), 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   acc;
        int   pops0;
        int   done_seen;
        exp_t snap;

        rst_i = 1'b1; bucket_i = 4'h0; payload_i = 16'h0000; valid_i = 1'b0; ready_i = 1'b1;
        wr_addr_i = 4'h0; wr_data_ptr_i = 8'h00; wr_data_ptr_val_i = 1'b0; wr_en_i = 1'b0;
        clear_run_i = 1'b0;
        step(); step(); step();
        rst_i = 1'b0;

        // Reset state
        check("rst_valid_o", valid_o, 1'b0);
        check("rst_clear_done_o", clear_done_o, 1'b0);
        check("rst_ready_o", ready_o, 1'b1);
        check("rst_outputs", {bucket_o, payload_o, head_ptr_val_o, head_ptr_o}, 29'h0);

        // Clear with a mid-clear write to an already-cleared address
        clear_run_i = 1'b1;
        step();
        clear_run_i = 1'b0;
        model_clearing = 1'b1;
        check("clear_ready_low", ready_o, 1'b0);
        n = 1;
        wr_addr_i = 4'h2; wr_data_ptr_i = 8'h77; wr_data_ptr_val_i = 1'b1;
        while (!clear_done_o && n < 40) begin
            wr_en_i = (n == 10);
            step();
            n++;
        end
        wr_en_i = 1'b0;
        check("clear_done_cycle", n, 17);
        step();
        check("clear_done_one_cycle", clear_done_o, 1'b0);
        check("clear_ready_back", ready_o, 1'b1);
        for (int i = 0; i < (1 << BW); i++) tbl[i] = 9'h000;
        model_clearing = 1'b0;

        // Read back every bucket: all must be empty chains
        pops0 = pops;
        for (int i = 0; i < (1 << BW); i++) send(4'(i), 16'(16'h0200 + i));
        drain();
        check("clear_readback_count", pops - pops0, 16);

        // Basic lookup
        wr_addr_i = 4'h5; wr_data_ptr_i = 8'h12; wr_data_ptr_val_i = 1'b1; wr_en_i = 1'b1;
        step();
        wr_en_i = 1'b0;
        send(4'h5, 16'h00a5);
        drain();
        check("lookup5_ptr", last_ptr, 8'h12);
        check("lookup5_val", last_val, 1'b1);
        send(4'h6, 16'h00a6);
        drain();
        check("lookup6_val", last_val, 1'b0);

        // Latency from the sampling edge, empty FIFO
        bucket_i = 4'h5; payload_i = 16'h0bee; valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        check("lat_edge0", valid_o, 1'b0);
        step();
        check("lat_edge1", valid_o, 1'b0);
        step();
        check("lat_edge2", valid_o, 1'b1);
        drain();

        // Same-cycle write/accept hazard
        bucket_i = 4'h3; payload_i = 16'h0333; valid_i = 1'b1;
        wr_addr_i = 4'h3; wr_data_ptr_i = 8'h44; wr_data_ptr_val_i = 1'b1; wr_en_i = 1'b1;
        step();
        valid_i = 1'b0; wr_en_i = 1'b0;
        drain();
        check("hazard_same_cycle", last_ptr, 8'h44);

        // Write one cycle after acceptance
        send(4'h3, 16'h0334);
        wr_addr_i = 4'h3; wr_data_ptr_i = 8'h55; wr_data_ptr_val_i = 1'b1; wr_en_i = 1'b1;
        step();
        wr_en_i = 1'b0;
        drain();
        check("hazard_next_cycle", last_ptr, 8'h55);

        // Backpressure: stream 8 with ready_i low
        ready_i = 1'b0;
        acc = 0;
        pops0 = pops;
        for (int i = 0; i < 8; i++) begin
            bucket_i = 4'(i); payload_i = 16'(16'h0100 + i); valid_i = 1'b1;
            if (ready_o) acc++;
            step();
        end
        valid_i = 1'b0;
        check("bp_accepted", acc, OD);
        check("bp_ready_low", ready_o, 1'b0);
        snap = {bucket_o, payload_o, head_ptr_val_o, head_ptr_o};
        step();
        check("bp_hold_valid", valid_o, 1'b1);
        check("bp_hold_stable", {bucket_o, payload_o, head_ptr_val_o, head_ptr_o}, snap);
        drain();
        check("bp_emerged", pops - pops0, OD);

        // Random traffic with bypass-heavy bucket range
        for (int i = 0; i < 300; i++) begin
            valid_i   = ($urandom_range(3) != 0);
            bucket_i  = 4'($urandom_range(3));
            payload_i = 16'($urandom);
            ready_i   = ($urandom_range(2) != 0);
            wr_en_i   = ($urandom_range(2) == 0);
            wr_addr_i = 4'($urandom_range(3));
            wr_data_ptr_i     = 8'($urandom);
            wr_data_ptr_val_i = 1'($urandom);
            step();
        end
        drain();

        // Reset in the middle of a clear with commands buffered
        ready_i = 1'b0;
        send(4'h7, 16'h0707);
        send(4'h8, 16'h0808);
        clear_run_i = 1'b1;
        step();
        clear_run_i = 1'b0;
        model_clearing = 1'b1;
        step(); step(); step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("midrst_valid_o", valid_o, 1'b0);
        check("midrst_ready_o", ready_o, 1'b1);
        check("midrst_done", clear_done_o, 1'b0);
        ready_i = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (clear_done_o) done_seen++;
        end
        check("midrst_no_done", done_seen, 0);
        check("midrst_no_output", valid_o, 1'b0);
        model_clearing = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
